// File: rtl/traffic_countdown_ctrl_pkg.sv
// Shared phase encoding, lamp codes and counter width for the traffic countdown controller.
// Also provides the binary to BCD helper used for the digit registers.
package traffic_countdown_ctrl_pkg;

    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        A_GREEN  = 2'd0,
        A_YELLOW = 2'd1,
        B_GREEN  = 2'd2,
        B_YELLOW = 2'd3
    } phase_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Repeated subtraction; nine steps cover the whole 0..99 display range.
    function automatic logic [7:0] bin2bcd(input logic [CNT_W-1:0] bin);
        logic [3:0]       tens;
        logic [CNT_W-1:0] rem;
        tens = 4'd0;
        rem  = bin;
        for (int i = 0; i < 9; i++) begin
            if (rem >= CNT_W'(10)) begin
                rem  = rem - CNT_W'(10);
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/traffic_countdown_ctrl_sec_tick_gen.sv
// Divides sys_clk down to a one-cycle pulse per second; tick is registered (CLK_FREQ cycles after reset).
// en low freezes the prescaler and masks the tick; a tick caught by en dropping is delivered on resume.
module sec_tick_gen #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    output logic sec_tick
);

    localparam int              PW   = $clog2(CLK_FREQ);
    localparam logic [PW-1:0]   LAST = PW'(CLK_FREQ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;

    always_comb begin
        presc_d = presc_q;
        tick_d  = tick_q;
        if (en) begin
            tick_d  = (presc_q == LAST);
            presc_d = tick_d ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign sec_tick = tick_q & en;

endmodule

// File: rtl/traffic_countdown_ctrl.sv
// Two-direction traffic phase FSM with per-direction countdowns shown as registered BCD digits.
// Lamps change on the phase edge, digits lag counters by one cycle; en low freezes everything.
module traffic_countdown_ctrl
    import traffic_countdown_ctrl_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int GREEN_TIME  = 25,
    parameter int YELLOW_TIME = 5
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       en,
    output logic [2:0] led_a,
    output logic [2:0] led_b,
    output logic [3:0] a_tens,
    output logic [3:0] a_units,
    output logic [3:0] b_tens,
    output logic [3:0] b_units,
    output logic       sec_tick
);

    if (GREEN_TIME + YELLOW_TIME > 99 || GREEN_TIME < 1 || YELLOW_TIME < 1 || CLK_FREQ < 2) begin : g_param_check
        $error("traffic_countdown_ctrl: invalid timing parameters");
    end

    localparam logic [CNT_W-1:0] T_GRN   = CNT_W'(GREEN_TIME);
    localparam logic [CNT_W-1:0] T_YEL   = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] T_RED   = CNT_W'(GREEN_TIME + YELLOW_TIME);
    localparam logic [7:0]       RST_A   = bin2bcd(T_GRN);
    localparam logic [7:0]       RST_B   = bin2bcd(T_RED);

    function automatic logic [2:0] lamp_a(input phase_t ph);
        case (ph)
            A_GREEN:  return LAMP_GRN;
            A_YELLOW: return LAMP_YEL;
            default:  return LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] lamp_b(input phase_t ph);
        case (ph)
            B_GREEN:  return LAMP_GRN;
            B_YELLOW: return LAMP_YEL;
            default:  return LAMP_RED;
        endcase
    endfunction

    // Length of the interval that follows the lamp currently lit.
    function automatic logic [CNT_W-1:0] next_len(input logic [2:0] lamp);
        case (lamp)
            LAMP_GRN: return T_YEL;
            LAMP_YEL: return T_RED;
            default:  return T_GRN;
        endcase
    endfunction

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [2:0]       led_a_q, led_a_d, led_b_q, led_b_d;
    logic [7:0]       bcd_a_q, bcd_a_d, bcd_b_q, bcd_b_d;

    sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .sec_tick  (sec_tick)
    );

    always_comb begin
        phase_d = phase_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (sec_tick) begin
            cnt_a_d = (cnt_a_q > CNT_W'(1)) ? cnt_a_q - CNT_W'(1) : next_len(lamp_a(phase_q));
            cnt_b_d = (cnt_b_q > CNT_W'(1)) ? cnt_b_q - CNT_W'(1) : next_len(lamp_b(phase_q));
            // The non-red side owns the phase timing.
            case (phase_q)
                A_GREEN:  if (cnt_a_q == CNT_W'(1)) phase_d = A_YELLOW;
                A_YELLOW: if (cnt_a_q == CNT_W'(1)) phase_d = B_GREEN;
                B_GREEN:  if (cnt_b_q == CNT_W'(1)) phase_d = B_YELLOW;
                default:  if (cnt_b_q == CNT_W'(1)) phase_d = A_GREEN;
            endcase
        end
        led_a_d = lamp_a(phase_d);
        led_b_d = lamp_b(phase_d);
        bcd_a_d = bin2bcd(cnt_a_q);
        bcd_b_d = bin2bcd(cnt_b_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_q <= A_GREEN;
            cnt_a_q <= T_GRN;
            cnt_b_q <= T_RED;
            led_a_q <= LAMP_GRN;
            led_b_q <= LAMP_RED;
            bcd_a_q <= RST_A;
            bcd_b_q <= RST_B;
        end else begin
            phase_q <= phase_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            led_a_q <= led_a_d;
            led_b_q <= led_b_d;
            bcd_a_q <= bcd_a_d;
            bcd_b_q <= bcd_b_d;
        end
    end

    assign led_a   = led_a_q;
    assign led_b   = led_b_q;
    assign a_tens  = bcd_a_q[7:4];
    assign a_units = bcd_a_q[3:0];
    assign b_tens  = bcd_b_q[7:4];
    assign b_units = bcd_b_q[3:0];

endmodule
